// File: rtl/waterfall_pkg.sv
// -----------------------------------------------------------------------------
// waterfall_pkg
// Shared types and constants for the LED waterfall input conditioner.
//   - btn_state_e  : button debounce FSM states
//   - DEF_*        : default debounce / long-press cycle counts (100 MHz clock)
//   - FREQ_*       : freq_set encodings understood by the waterfall driver
// -----------------------------------------------------------------------------
package waterfall_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        PRESS_CHK   = 2'b01,
        HELD        = 2'b10,
        RELEASE_CHK = 2'b11
    } btn_state_e;

    // 10 ms of stable input at 100 MHz before a new level is believed
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
    // 2 s of continuous hold before long_press fires
    localparam int unsigned DEF_LONG_CYCLES     = 32'd200_000_000;

    localparam logic [1:0] FREQ_1X  = 2'b00;
    localparam logic [1:0] FREQ_2X  = 2'b01;
    localparam logic [1:0] FREQ_5X  = 2'b10;
    localparam logic [1:0] FREQ_10X = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing asynchronous board inputs into the clk domain.
// Ports:
//   i_clk  : destination clock
//   i_rst  : synchronous active-high reset, clears both stages
//   i_d    : asynchronous input bits [WIDTH-1:0]
//   o_q    : synchronized output bits, two clk cycles behind i_d
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a full cycle to settle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= {WIDTH{1'b0}};
            r_sync <= {WIDTH{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/waterfall_input_ctrl.sv
// -----------------------------------------------------------------------------
// waterfall_input_ctrl
// Conditions raw board inputs for the LED waterfall driver: the push-button
// becomes a debounced one-cycle start pulse plus a debounced level, and the
// 2-bit DIP switch becomes a debounced frequency select with a change pulse.
//
// Ports:
//   clk            : system clock
//   rst            : synchronous active-high reset
//   btn_start_raw  : raw push-button (async, bouncy, 1 = pressed)
//   sw_freq_raw    : raw DIP switches (async, bouncy)
//   start_pulse    : one-cycle pulse per accepted press
//   btn_level      : debounced button level
//   freq_set       : debounced frequency select (FREQ_* encoding)
//   freq_changed   : one-cycle pulse when freq_set updates
//   long_press     : one-cycle pulse after a long hold
//
// Build option:
//   WATERFALL_LONG_PRESS_EN : when defined, a hold counter drives long_press;
//                             otherwise long_press is tied to 0.
// -----------------------------------------------------------------------------
module waterfall_input_ctrl
    import waterfall_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_raw,
    input  logic [1:0] sw_freq_raw,
    output logic       start_pulse,
    output logic       btn_level,
    output logic [1:0] freq_set,
    output logic       freq_changed,
    output logic       long_press
);

    localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    // ---------------------------------------------------------------- sync
    logic [2:0] w_sync;
    logic       w_btn_s;
    logic [1:0] w_sw_s;

    sync_2ff #(
        .WIDTH (3)
    ) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   ({btn_start_raw, sw_freq_raw}),
        .o_q   (w_sync)
    );

    assign w_btn_s = w_sync[2];
    assign w_sw_s  = w_sync[1:0];

    // ---------------------------------------------------------- button FSM
    btn_state_e    r_state;
    btn_state_e    w_state_nxt;
    logic [CW-1:0] r_btn_cnt;
    logic [CW-1:0] w_btn_cnt_nxt;
    logic          r_start_pulse;
    logic          w_start_pulse_nxt;
    logic          r_btn_level;
    logic          w_btn_level_nxt;

    // Button FSM state, debounce count and registered button outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_btn_cnt     <= {CW{1'b0}};
            r_start_pulse <= 1'b0;
            r_btn_level   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_btn_cnt     <= w_btn_cnt_nxt;
            r_start_pulse <= w_start_pulse_nxt;
            r_btn_level   <= w_btn_level_nxt;
        end
    end

    // Next-state logic; count tracks consecutive samples at the candidate level
    always_comb begin
        w_state_nxt       = r_state;
        w_btn_cnt_nxt     = r_btn_cnt;
        w_start_pulse_nxt = 1'b0;
        w_btn_level_nxt   = r_btn_level;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt   = PRESS_CHK;
                    w_btn_cnt_nxt = CNT_ONE;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            PRESS_CHK: begin
                if (!w_btn_s) begin
                    // bounce: drop the partial count, no pulse
                    w_state_nxt = IDLE;
                end else if (r_btn_cnt == CNT_MAX) begin
                    w_state_nxt       = HELD;
                    w_start_pulse_nxt = 1'b1;
                    w_btn_level_nxt   = 1'b1;
                end else begin
                    w_btn_cnt_nxt = r_btn_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt   = RELEASE_CHK;
                    w_btn_cnt_nxt = CNT_ONE;
                end else begin
                    w_state_nxt   = HELD;
                end
            end
            RELEASE_CHK: begin
                if (w_btn_s) begin
                    // release bounce: back to HELD without a second pulse
                    w_state_nxt = HELD;
                end else if (r_btn_cnt == CNT_MAX) begin
                    w_state_nxt     = IDLE;
                    w_btn_level_nxt = 1'b0;
                end else begin
                    w_btn_cnt_nxt = r_btn_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_btn_cnt_nxt   = {CW{1'b0}};
                w_btn_level_nxt = 1'b0;
            end
        endcase
    end

    assign start_pulse = r_start_pulse;
    assign btn_level   = r_btn_level;

    // ------------------------------------------------------- switch filter
    logic [1:0]    r_sw_cand;
    logic [CW-1:0] r_sw_cnt;
    logic [1:0]    r_freq_set;
    logic          r_freq_changed;

    // Candidate/count track how long sw_s has been steady; commit once it has
    // been steady for DEBOUNCE_CYCLES samples and differs from freq_set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_cand      <= FREQ_1X;
            r_sw_cnt       <= {CW{1'b0}};
            r_freq_set     <= FREQ_1X;
            r_freq_changed <= 1'b0;
        end else begin
            if (w_sw_s != r_sw_cand) begin
                r_sw_cand <= w_sw_s;
                r_sw_cnt  <= CNT_ONE;
            end else if (r_sw_cnt != CNT_MAX) begin
                r_sw_cnt  <= r_sw_cnt + CNT_ONE;
            end else begin
                r_sw_cnt  <= r_sw_cnt;
            end

            if ((r_sw_cnt == CNT_MAX) && (r_sw_cand != r_freq_set)) begin
                r_freq_set     <= r_sw_cand;
                r_freq_changed <= 1'b1;
            end else begin
                r_freq_set     <= r_freq_set;
                r_freq_changed <= 1'b0;
            end
        end
    end

    assign freq_set     = r_freq_set;
    assign freq_changed = r_freq_changed;

    // ---------------------------------------------------------- long press
`ifdef WATERFALL_LONG_PRESS_EN
    localparam int unsigned    HW        = $clog2(LONG_CYCLES + 32'd1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 32'd1);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);

    logic [HW-1:0] r_hold_cnt;
    logic          r_long_press;

    // Hold time accumulates only in HELD, pauses across release bounces and
    // saturates so a single hold yields a single pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt   <= {HW{1'b0}};
            r_long_press <= 1'b0;
        end else begin
            case (r_state)
                HELD: begin
                    if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt;
                    end
                    r_long_press <= (r_hold_cnt == HOLD_LAST);
                end
                RELEASE_CHK: begin
                    r_hold_cnt   <= r_hold_cnt;
                    r_long_press <= 1'b0;
                end
                default: begin
                    r_hold_cnt   <= {HW{1'b0}};
                    r_long_press <= 1'b0;
                end
            endcase
        end
    end

    assign long_press = r_long_press;
`else
    logic w_unused_long_cfg;
    assign w_unused_long_cfg = (LONG_CYCLES != 32'd0);
    assign long_press        = 1'b0;
`endif

endmodule

// File: tb/tb_waterfall_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_waterfall_input_ctrl
// Directed scenarios followed by randomized input bursts. Every cycle the DUT
// outputs are compared against a reference model that works on sample
// histories: a level is accepted once the last DEB+1 synchronized samples all
// disagree with the current level; a switch value is committed once the last
// DEB synchronized samples all agree and differ from the current select.
// -----------------------------------------------------------------------------
module tb_waterfall_input_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [1:0] sw;
    logic       start_pulse;
    logic       btn_level;
    logic [1:0] freq_set;
    logic       freq_changed;
    logic       long_press;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // observation counters for directed scenarios
    int n_pulse, n_fc, n_lp;
    int last_pulse, last_fc, last_lp;
    int edge_ref;

    // reference model state
    logic       m_level, m_pulse, m_fc, m_lp;
    logic [1:0] m_freq;
    logic       bh[$];
    logic [1:0] sh[$];
    logic [2:0] sq[$];
`ifdef WATERFALL_LONG_PRESS_EN
    int         m_hc;
`endif

    always #5 clk = ~clk;

    waterfall_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start_raw (btn),
        .sw_freq_raw   (sw),
        .start_pulse   (start_pulse),
        .btn_level     (btn_level),
        .freq_set      (freq_set),
        .freq_changed  (freq_changed),
        .long_press    (long_press)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic model_step();
        logic [2:0] samp;
        logic       differ_all;
        logic       same_all;
        if (rst) begin
            sq.delete();
            sq.push_back(3'b000);
            sq.push_back(3'b000);
            bh.delete();
            sh.delete();
            m_level = 1'b0;
            m_pulse = 1'b0;
            m_freq  = 2'b00;
            m_fc    = 1'b0;
            m_lp    = 1'b0;
`ifdef WATERFALL_LONG_PRESS_EN
            m_hc    = 0;
`endif
        end else begin
            // the logic sees what the raw pins held two edges ago
            samp = sq.pop_front();
            sq.push_back({btn, sw});

`ifdef WATERFALL_LONG_PRESS_EN
            m_lp = 1'b0;
            if (!m_level) begin
                m_hc = 0;
            end else if ((bh.size() == 0 || bh[$] == 1'b1) && m_hc < LONG) begin
                m_hc++;
                if (m_hc == LONG) m_lp = 1'b1;
            end
`else
            m_lp = 1'b0;
`endif

            // button
            m_pulse = 1'b0;
            bh.push_back(samp[2]);
            if (bh.size() > DEB + 1) void'(bh.pop_front());
            differ_all = (bh.size() == DEB + 1);
            foreach (bh[i]) if (bh[i] == m_level) differ_all = 1'b0;
            if (differ_all) begin
                m_level = ~m_level;
                m_pulse = m_level;
                bh.delete();
            end

            // switches
            m_fc = 1'b0;
            same_all = (sh.size() == DEB);
            foreach (sh[i]) if (sh[i] != sh[0]) same_all = 1'b0;
            if (same_all && sh[0] != m_freq) begin
                m_freq = sh[0];
                m_fc   = 1'b1;
            end
            sh.push_back(samp[1:0]);
            if (sh.size() > DEB) void'(sh.pop_front());
        end
    endtask

    // One clock: drive inputs, let the edge happen, check on the falling edge
    task automatic cyc(input logic r, input logic b, input logic [1:0] s);
        rst = r;
        btn = b;
        sw  = s;
        @(posedge clk);
        cyc_n++;
        model_step();
        @(negedge clk);
        chk("start_pulse",  {1'b0, start_pulse},  {1'b0, m_pulse});
        chk("btn_level",    {1'b0, btn_level},    {1'b0, m_level});
        chk("freq_set",     freq_set,             m_freq);
        chk("freq_changed", {1'b0, freq_changed}, {1'b0, m_fc});
        chk("long_press",   {1'b0, long_press},   {1'b0, m_lp});
        if (start_pulse === 1'b1)  begin n_pulse++; last_pulse = cyc_n; end
        if (freq_changed === 1'b1) begin n_fc++;    last_fc    = cyc_n; end
        if (long_press === 1'b1)   begin n_lp++;    last_lp    = cyc_n; end
    endtask

    task automatic hold(input logic b, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, b, s);
    endtask

    initial begin
        n_pulse = 0; n_fc = 0; n_lp = 0;
        last_pulse = 0; last_fc = 0; last_lp = 0; edge_ref = 0;

        // reset state
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'b00);
        hold(1'b0, 2'b00, 5);

        // clean press
        n_pulse = 0;
        edge_ref = cyc_n;
        hold(1'b1, 2'b00, 30);
        chk_int("clean_press_count", n_pulse, 1);
        chk_int("clean_press_latency", last_pulse - edge_ref, DEB + 3);
        chk("clean_press_level", {1'b0, btn_level}, 2'b01);
        hold(1'b0, 2'b00, 20);
        chk("release_level", {1'b0, btn_level}, 2'b00);

        // bouncy press: 1,0,1,0 then steady 1
        n_pulse = 0;
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 2'b00);
        edge_ref = cyc_n;
        hold(1'b1, 2'b00, 20);
        chk_int("bouncy_press_count", n_pulse, 1);
        chk_int("bouncy_press_latency", last_pulse - edge_ref, DEB + 3);
        hold(1'b0, 2'b00, 20);

        // short glitch
        n_pulse = 0;
        hold(1'b1, 2'b00, 3);
        hold(1'b0, 2'b00, 15);
        chk_int("glitch_count", n_pulse, 0);
        chk("glitch_level", {1'b0, btn_level}, 2'b00);

        // switch change 00 -> 10
        n_fc = 0;
        edge_ref = cyc_n;
        hold(1'b0, 2'b10, 15);
        chk_int("sw_change_count", n_fc, 1);
        chk_int("sw_change_latency", last_fc - edge_ref, DEB + 3);
        chk("sw_change_value", freq_set, 2'b10);

        // 10 -> 11 -> 10 too quickly to be accepted
        n_fc = 0;
        hold(1'b0, 2'b11, 2);
        hold(1'b0, 2'b10, 15);
        chk_int("sw_glitch_count", n_fc, 0);
        chk("sw_glitch_value", freq_set, 2'b10);

        // reset while in PRESS_CHK with the button held
        hold(1'b1, 2'b10, 5);
        cyc(1'b1, 1'b1, 2'b10);
        chk("rst_freq_set", freq_set, 2'b00);
        chk("rst_level", {1'b0, btn_level}, 2'b00);
        chk("rst_pulse", {1'b0, start_pulse}, 2'b00);
        n_pulse = 0;
        edge_ref = cyc_n;
        hold(1'b1, 2'b10, 20);
        chk_int("rst_hold_count", n_pulse, 1);
        chk_int("rst_hold_latency", last_pulse - edge_ref, DEB + 3);
        hold(1'b0, 2'b10, 20);

        // long hold
        n_pulse = 0;
        n_lp = 0;
        edge_ref = cyc_n;
        hold(1'b1, 2'b01, 40);
        chk_int("long_hold_pulses", n_pulse, 1);
`ifdef WATERFALL_LONG_PRESS_EN
        chk_int("long_press_count", n_lp, 1);
        chk_int("long_press_delay", last_lp - last_pulse, LONG);
`else
        chk_int("long_press_count", n_lp, 0);
`endif
        hold(1'b0, 2'b01, 20);

        // randomized bursts: short ones look like bounce, long ones get accepted
        for (int i = 0; i < 300; i++) begin
            logic       rb;
            logic [1:0] rs;
            int         len;
            rb  = 1'($urandom_range(0, 1));
            rs  = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 30))
                                              : int'($urandom_range(1, 5));
            if ($urandom_range(0, 49) == 0) begin
                cyc(1'b1, rb, rs);
            end else begin
                hold(rb, rs, len);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
